// File: rtl/shared_gf2_mulsqsc_pipe.sv
// ---------------------------------------------------------------------------
// shared_gf2_mulsqsc_pipe
//
// Masked (Boolean-shared) GF(2^2) multiply / multiply-plus-square-scale
// gadget with a valid/ready pipeline. Each lane holds a full SHARES x SHARES
// matrix of cross-product registers. Off-diagonal products are re-masked with
// fresh randomness before being registered. The output shares are XOR
// compressions of those registers only.
//
// Ports
//   ClkxCI       : clock, rising edge
//   RstxRI       : synchronous active-high reset
//   InValidxSI   : operand set presented
//   InReadyxSO   : operand set accepted this cycle (combinational from
//                  OutReadyxSI)
//   ModexSI      : 0 -> Q = X*B, 1 -> Q = X*B ^ sqsc(X^Y)
//   _XxDI/_BxDI/_YxDI : shared operands, lane l share i bit j at
//                  (l*SHARES+i)*2+j
//   _ZxDI        : fresh randomness, lane l pair p bit j at (l*P+p)*2+j
//   OutValidxSO  : _QxDO holds a valid result
//   OutReadyxSI  : downstream takes the result
//   _QxDO        : shared result, same layout as _XxDI
//
// LATENCY=1 : cross-product register stage, combinational compression.
// LATENCY=2 : compressed shares are registered as well.
// ---------------------------------------------------------------------------
module shared_gf2_mulsqsc_pipe #(
    parameter int SHARES  = 2,
    parameter int LANES   = 1,
    parameter int LATENCY = 1,
    localparam int P      = SHARES * (SHARES - 1) / 2
) (
    input  logic                      ClkxCI,
    input  logic                      RstxRI,
    input  logic                      InValidxSI,
    output logic                      InReadyxSO,
    input  logic                      ModexSI,
    input  logic [2*SHARES*LANES-1:0] _XxDI,
    input  logic [2*SHARES*LANES-1:0] _BxDI,
    input  logic [2*SHARES*LANES-1:0] _YxDI,
    input  logic [2*P*LANES-1:0]      _ZxDI,
    output logic                      OutValidxSO,
    input  logic                      OutReadyxSI,
    output logic [2*SHARES*LANES-1:0] _QxDO
);

    localparam int LW = 2 * SHARES;  // data bits per lane
    localparam int ZW = 2 * P;       // randomness bits per lane

    // ------------------------------------------------------------------
    // Handshake control, shared by all lanes
    // ------------------------------------------------------------------
    logic vff_q, vff_d;   // cross-product stage holds a result
    logic nxt_adv;        // stage behind the FF stage takes data this cycle
    logic ff_adv;         // FF stage may load this cycle
    logic in_fire;        // operand transfer at the coming edge

    logic [2*SHARES*LANES-1:0] comp;  // compressed shares of all lanes

    // The FF stage advances when it is empty or its result leaves.
    assign ff_adv     = !vff_q || nxt_adv;
    assign InReadyxSO = ff_adv;
    assign in_fire    = InValidxSI && ff_adv;

    // When advancing, the stage takes whatever is offered (possibly a
    // bubble); otherwise it holds.
    assign vff_d = ff_adv ? InValidxSI : vff_q;

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            vff_q <= 1'b0;
        end else begin
            vff_q <= vff_d;
        end
    end

    // ------------------------------------------------------------------
    // Lanes: fully independent datapaths, common load enable
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        shared_gf2_mulsqsc_lane #(
            .SHARES (SHARES),
            .P      (P)
        ) u_lane (
            .ClkxCI (ClkxCI),
            .RstxRI (RstxRI),
            .ff_en_i(in_fire),
            .mode_i (ModexSI),
            .x_i    (_XxDI[l*LW +: LW]),
            .b_i    (_BxDI[l*LW +: LW]),
            .y_i    (_YxDI[l*LW +: LW]),
            .z_i    (_ZxDI[l*ZW +: ZW]),
            .comp_o (comp[l*LW +: LW])
        );
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    if (LATENCY == 2) begin : g_lat2
        logic                      vout_q, vout_d;
        logic [2*SHARES*LANES-1:0] q_q, q_d;

        assign nxt_adv = !vout_q || OutReadyxSI;

        always_comb begin
            vout_d = vout_q;
            q_d    = q_q;
            if (nxt_adv) begin
                vout_d = vff_q;
                // Data only changes when a real result moves in, so a
                // bubble leaves the last value on the bus.
                if (vff_q) begin
                    q_d = comp;
                end
            end
        end

        always_ff @(posedge ClkxCI) begin
            if (RstxRI) begin
                vout_q <= 1'b0;
                q_q    <= '0;
            end else begin
                vout_q <= vout_d;
                q_q    <= q_d;
            end
        end

        assign OutValidxSO = vout_q;
        assign _QxDO       = q_q;
    end else begin : g_lat1
        // Output handshake completes whenever vFF is set and downstream is
        // ready; !vFF is already covered by ff_adv.
        assign nxt_adv     = OutReadyxSI;
        assign OutValidxSO = vff_q;
        assign _QxDO       = comp;
    end

endmodule

// ---------------------------------------------------------------------------
// shared_gf2_mulsqsc_lane
//
// One GF(2^2) gadget lane. Registers FF[k][l] = mul(X_k, B_l) ^ mask, where
// the diagonal mask is the optional square-scale term of share k and the
// off-diagonal masks use one fresh pair value for both FF[k][l] and FF[l][k]
// so that it cancels in the unmasked result.
//
// Ports
//   ClkxCI, RstxRI : clock, synchronous active-high reset
//   ff_en_i        : load the cross-product registers
//   mode_i         : add sqsc(X_k ^ Y_k) on the diagonal
//   x_i, b_i, y_i  : shares of this lane, share i at bits [2i+1:2i]
//   z_i            : fresh randomness, pair p at bits [2p+1:2p]
//   comp_o         : compressed output shares (from registers only)
// ---------------------------------------------------------------------------
module shared_gf2_mulsqsc_lane #(
    parameter int SHARES = 2,
    parameter int P      = 1
) (
    input  logic                ClkxCI,
    input  logic                RstxRI,
    input  logic                ff_en_i,
    input  logic                mode_i,
    input  logic [2*SHARES-1:0] x_i,
    input  logic [2*SHARES-1:0] b_i,
    input  logic [2*SHARES-1:0] y_i,
    input  logic [2*P-1:0]      z_i,
    output logic [2*SHARES-1:0] comp_o
);

    // FF[k][l] lives at bits [2*(k*SHARES+l) +: 2]
    logic [2*SHARES*SHARES-1:0] ff_d, ff_q;

    // Normal basis {W^2, W} multiplier.
    function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
        logic c;
        c = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ c, (a[0] & b[0]) ^ c};
    endfunction

    // W^2 * a^2 in the same basis.
    function automatic logic [1:0] gf_sqsc(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    for (genvar k = 0; k < SHARES; k++) begin : g_row
        for (genvar l = 0; l < SHARES; l++) begin : g_col
            logic [1:0] mask;

            if (k == l) begin : g_diag
                // Square-scale is linear, so it can be applied share-wise.
                assign mask = mode_i ? gf_sqsc(x_i[2*k +: 2] ^ y_i[2*k +: 2]) : 2'b00;
            end else if (k < l) begin : g_upper
                assign mask = z_i[2*(k + l*(l-1)/2) +: 2];
            end else begin : g_lower
                assign mask = z_i[2*(l + k*(k-1)/2) +: 2];
            end

            assign ff_d[2*(k*SHARES+l) +: 2] = gf_mul(x_i[2*k +: 2], b_i[2*l +: 2]) ^ mask;
        end
    end

    // Loads only on accepted transfers, so randomness is consumed only then.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            ff_q <= '0;
        end else if (ff_en_i) begin
            ff_q <= ff_d;
        end
    end

    // Output share k is the XOR of row k; only registered terms are mixed.
    always_comb begin
        comp_o = '0;
        for (int k = 0; k < SHARES; k++) begin
            for (int l = 0; l < SHARES; l++) begin
                comp_o[2*k +: 2] = comp_o[2*k +: 2] ^ ff_q[2*(k*SHARES+l) +: 2];
            end
        end
    end

endmodule
